// File: rtl/reset_sequencer.sv
// Reset release sequencer: filters PLL lock, holds, then releases reset channels in order.
// Optional lock-loss event counter is enabled by defining RSTSEQ_LOCK_LOSS_CNT_EN.
module reset_sequencer #(
    parameter int NUM_OUT     = 3,
    parameter int LOCK_SYNC   = 2,
    parameter int LOCK_FILT   = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               pll_lock,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               done
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]         lock_loss_cnt
`endif
);

    // state       | meaning
    // S_WAIT_LOCK | all channels in reset, waiting for filtered lock and no request
    // S_HOLD      | lock good, counting HOLD_CYCLES before the first release
    // S_RELEASE   | releasing channels one by one every STAGE_GAP cycles
    // S_RUN       | every channel released, done high
    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_RELEASE   = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    localparam logic [3:0]  FILT_MAX   = 4'(LOCK_FILT);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]  STAGE_LOAD = 8'(STAGE_GAP - 1);

    logic [LOCK_SYNC-1:0] sync_q;
    logic                 lock_sync;
    logic [3:0]           filt_q;
    logic                 lock_ok;

    logic [1:0]         state_q, state_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               done_q, done_d;
    logic [15:0]        hold_q, hold_d;
    logic [7:0]         stage_q, stage_d;

    assign lock_sync = sync_q[LOCK_SYNC-1];
    assign lock_ok   = (filt_q == FILT_MAX);

    // Synchroniser and lock filter run regardless of req and sequencing state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            filt_q <= '0;
        end else begin
            sync_q <= {sync_q[LOCK_SYNC-2:0], pll_lock};
            if (!lock_sync) begin
                filt_q <= '0;
            end else if (filt_q != FILT_MAX) begin
                filt_q <= filt_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        done_d  = done_q;
        hold_d  = hold_q;
        stage_d = stage_q;
        if (req || !lock_ok) begin
            state_d = S_WAIT_LOCK;
            out_d   = '1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LOAD;
                end
                S_HOLD: begin
                    if (hold_q == 16'd0) begin
                        out_d   = out_q << 1;
                        stage_d = STAGE_LOAD;
                        state_d = (out_d == '0) ? S_RUN : S_RELEASE;
                        done_d  = (out_d == '0);
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
                S_RELEASE: begin
                    if (stage_q == 8'd0) begin
                        out_d   = out_q << 1;
                        stage_d = STAGE_LOAD;
                        state_d = (out_d == '0) ? S_RUN : S_RELEASE;
                        done_d  = (out_d == '0);
                    end else begin
                        stage_d = stage_q - 8'd1;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    out_d   = '1;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_LOCK;
            out_q   <= '1;
            done_q  <= 1'b0;
            hold_q  <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            stage_q <= stage_d;
        end
    end

    assign reset_out = out_q;
    assign done      = done_q;

`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
    logic [7:0] loss_q;

    // Only lock loss out of an active sequence counts; req-driven restarts do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (!lock_ok && (state_q != S_WAIT_LOCK) && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized traffic vs. a timing model.
`timescale 1ns/1ps
module tb_reset_sequencer;
    localparam int NUM_OUT     = 3;
    localparam int LOCK_SYNC   = 2;
    localparam int LOCK_FILT   = 3;
    localparam int HOLD_CYCLES = 4;
    localparam int STAGE_GAP   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic pll_lock;
    logic [NUM_OUT-1:0] reset_out;
    logic done;
    logic [0:0] reset_out1;
    logic done1;
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
    logic [7:0] lock_loss_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_OUT(NUM_OUT), .LOCK_SYNC(LOCK_SYNC), .LOCK_FILT(LOCK_FILT),
                      .HOLD_CYCLES(HOLD_CYCLES), .STAGE_GAP(STAGE_GAP)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .pll_lock(pll_lock),
        .reset_out(reset_out), .done(done)
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    reset_sequencer #(.NUM_OUT(1), .LOCK_SYNC(LOCK_SYNC), .LOCK_FILT(LOCK_FILT),
                      .HOLD_CYCLES(HOLD_CYCLES), .STAGE_GAP(STAGE_GAP)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .pll_lock(pll_lock),
        .reset_out(reset_out1), .done(done1)
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(lock_loss_cnt1)
`endif
    );

    // Timing model: pll_lock delay line, run-length lock filter, and release times
    // computed arithmetically from the edge where a sequence started.
    bit                 m_dly[$];
    int                 m_run;
    bit                 m_active;
    int                 m_t0;
    int                 m_edge;
    int                 m_loss;
    logic [NUM_OUT-1:0] m_out;
    bit                 m_done;
    bit                 m_out1;
    bit                 m_done1;

    function automatic void model_clear();
        m_dly.delete();
        for (int i = 0; i < LOCK_SYNC; i++) m_dly.push_back(1'b0);
        m_run    = 0;
        m_active = 1'b0;
        m_t0     = 0;
        m_edge   = 0;
        m_loss   = 0;
        m_out    = '1;
        m_done   = 1'b0;
        m_out1   = 1'b1;
        m_done1  = 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            bit                 ok_b;
            bit                 sync_b;
            int                 k;
            int                 rel;
            logic [NUM_OUT-1:0] ones;
            ok_b   = (m_run == LOCK_FILT);
            sync_b = m_dly[LOCK_SYNC-1];
            m_edge++;
            if (req || !ok_b) begin
                if (m_active && !ok_b && m_loss < 255) m_loss++;
                m_active = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_t0     = m_edge;
            end
            m_run = sync_b ? ((m_run < LOCK_FILT) ? m_run + 1 : m_run) : 0;
            m_dly.push_front(pll_lock);
            void'(m_dly.pop_back());
            k    = m_edge - m_t0 - HOLD_CYCLES;
            rel  = (!m_active || k < 0) ? 0 : 1 + k / STAGE_GAP;
            if (rel > NUM_OUT) rel = NUM_OUT;
            ones    = '1;
            m_out   = ones << rel;
            m_done  = (rel == NUM_OUT);
            m_out1  = (rel == 0);
            m_done1 = (rel != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 1'($urandom);
        pll_lock = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            tick();
            req      = 1'($urandom);
            pll_lock = 1'($urandom);
            checks++;
            if (reset_out !== 3'b111 || done !== 1'b0 || reset_out1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: reset_out=%b done=%b out1=%b done1=%b, expected 111 0 1 0",
                         reset_out, done, reset_out1, done1);
            end
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
            checks++;
            if (lock_loss_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_loss_cnt: got %0d, expected 0", lock_loss_cnt);
            end
`endif
        end
    endtask

    task automatic test_release_timing();
        logic [2:0] exp_out;
        rst_n    = 1'b0;
        req      = 1'b0;
        pll_lock = 1'b0;
        tick();
        rst_n    = 1'b1;
        pll_lock = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_out = (e >= 14) ? 3'b000 : (e >= 12) ? 3'b100 : (e >= 10) ? 3'b110 : 3'b111;
            checks++;
            if (reset_out !== exp_out || done !== (e >= 14)) begin
                errors++;
                $display("FAIL release_timing edge %0d: reset_out=%b done=%b, expected %b %0d",
                         e, reset_out, done, exp_out, (e >= 14));
            end
            checks++;
            if (reset_out1 !== (e < 10) || done1 !== (e >= 10)) begin
                errors++;
                $display("FAIL release_timing_n1 edge %0d: out=%b done=%b, expected %0d %0d",
                         e, reset_out1, done1, (e < 10), (e >= 10));
            end
            checks++;
            if (reset_out !== m_out || done !== m_done) begin
                errors++;
                $display("FAIL release_model edge %0d: reset_out=%b done=%b, expected %b %0d",
                         e, reset_out, done, m_out, m_done);
            end
        end
    endtask

    task automatic test_lock_glitch();
        logic [2:0] exp_out;
        bit         exp_done;
        pll_lock = 1'b0;
        for (int j = 0; j <= 14; j++) begin
            tick();
            pll_lock = 1'b1;
            exp_out  = (j <= 2) ? 3'b000 : (j <= 9) ? 3'b111 : (j <= 11) ? 3'b110 :
                       (j <= 13) ? 3'b100 : 3'b000;
            exp_done = (j <= 2) || (j >= 14);
            checks++;
            if (reset_out !== exp_out || done !== exp_done) begin
                errors++;
                $display("FAIL lock_glitch step %0d: reset_out=%b done=%b, expected %b %0d",
                         j, reset_out, done, exp_out, exp_done);
            end
            checks++;
            if (reset_out1 !== (j >= 3 && j <= 9) || done1 !== !(j >= 3 && j <= 9)) begin
                errors++;
                $display("FAIL lock_glitch_n1 step %0d: out=%b done=%b", j, reset_out1, done1);
            end
        end
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL lock_glitch_loss_cnt: got %0d, expected 1", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_req_pulse();
        int loss_before;
        int budget;
        req = 1'b1;
        tick();
        req = 1'b0;
        budget = 0;
        while (m_out !== 3'b110 && budget < 40) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 40) begin
            errors++;
            $display("FAIL req_pulse_timeout: model never reached 110, reset_out=%b", reset_out);
        end
        checks++;
        if (reset_out !== 3'b110) begin
            errors++;
            $display("FAIL req_pulse_pre: reset_out=%b, expected 110", reset_out);
        end
        loss_before = m_loss;
        req = 1'b1;
        tick();
        req = 1'b0;
        checks++;
        if (reset_out !== 3'b111 || done !== 1'b0) begin
            errors++;
            $display("FAIL req_pulse_abort: reset_out=%b done=%b, expected 111 0", reset_out, done);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (reset_out !== ((k == 5) ? 3'b110 : 3'b111)) begin
                errors++;
                $display("FAIL req_pulse_restart step %0d: reset_out=%b, expected %b",
                         k, reset_out, (k == 5) ? 3'b110 : 3'b111);
            end
        end
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
        checks++;
        if (lock_loss_cnt !== 8'(loss_before)) begin
            errors++;
            $display("FAIL req_pulse_loss_cnt: got %0d, expected %0d", lock_loss_cnt, loss_before);
        end
`endif
    endtask

    task automatic test_async_abort();
        rst_n    = 1'b0;
        req      = 1'b0;
        pll_lock = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 15; e++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (reset_out !== 3'b111 || done !== 1'b0 || reset_out1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL async_abort_run: reset_out=%b done=%b out1=%b done1=%b, expected 111 0 1 0",
                     reset_out, done, reset_out1, done1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 7; e++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (reset_out !== 3'b111 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort_hold: reset_out=%b done=%b, expected 111 0", reset_out, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (reset_out !== ((e >= 10) ? 3'b110 : 3'b111)) begin
                errors++;
                $display("FAIL async_abort_restart edge %0d: reset_out=%b, expected %b",
                         e, reset_out, (e >= 10) ? 3'b110 : 3'b111);
            end
        end
    endtask

    task automatic test_filter_reject();
        for (int i = 0; i < 66; i++) begin
            pll_lock = ((i % 3) != 2);
            tick();
            if (i >= 6) begin
                checks++;
                if (reset_out !== 3'b111 || done !== 1'b0 || reset_out !== m_out) begin
                    errors++;
                    $display("FAIL filter_reject cycle %0d: reset_out=%b done=%b, expected 111 0",
                             i, reset_out, done);
                end
            end
        end
    endtask

    task automatic test_random();
        int drop_div;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) drop_div = $urandom_range(8, 60);
            pll_lock = ($urandom_range(0, drop_div - 1) != 0);
            req      = ($urandom_range(0, 59) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            tick();
            checks++;
            if (reset_out !== m_out || done !== m_done || reset_out1 !== m_out1 || done1 !== m_done1) begin
                errors++;
                $display("FAIL random cycle %0d: out=%b done=%b out1=%b done1=%b, expected %b %0d %0d %0d",
                         i, reset_out, done, reset_out1, done1, m_out, m_done, m_out1, m_done1);
            end
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
            checks++;
            if (lock_loss_cnt !== 8'(m_loss)) begin
                errors++;
                $display("FAIL random_loss_cnt cycle %0d: got %0d, expected %0d", i, lock_loss_cnt, m_loss);
            end
`endif
        end
        rst_n = 1'b1;
        req   = 1'b0;
    endtask

`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
    task automatic test_saturation();
        int budget;
        rst_n    = 1'b0;
        req      = 1'b0;
        pll_lock = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            budget = 0;
            while (!m_done && budget < 60) begin
                tick();
                budget++;
            end
            if (budget >= 60) begin
                checks++;
                errors++;
                $display("FAIL saturation_timeout event %0d: reset_out=%b", n, reset_out);
                break;
            end
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            for (int j = 0; j < 4; j++) tick();
        end
        for (int j = 0; j < 20; j++) tick();
        checks++;
        if (lock_loss_cnt !== 8'd255 || lock_loss_cnt1 !== 8'd255) begin
            errors++;
            $display("FAIL saturation: cnt=%0d cnt1=%0d, expected 255", lock_loss_cnt, lock_loss_cnt1);
        end
    endtask
`endif

    initial begin
        model_clear();
        rst_n    = 1'b0;
        req      = 1'b0;
        pll_lock = 1'b0;
        test_reset();
        test_release_timing();
        test_lock_glitch();
        test_req_pulse();
        test_async_abort();
        test_filter_reject();
        test_random();
`ifdef RSTSEQ_LOCK_LOSS_CNT_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 3: number of reset output channels, legal range 1..16.
REQ-002 SHALL have parameter LOCK_SYNC, default 2: pll_lock synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter LOCK_FILT, default 3: consecutive synchronised-high samples required for lock_ok, legal range 1..15.
REQ-004 SHALL have parameter HOLD_CYCLES, default 4: minimum cycles in HOLD before the first release, legal range 1..65535.
REQ-005 SHALL have parameter STAGE_GAP, default 2: cycles between successive channel releases, legal range 1..255.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port req, input, 1 bit: synchronous reset request, clk domain, active-high, not synchronised internally.
REQ-009 SHALL have port pll_lock, input, 1 bit: PLL lock indicator, asynchronous to clk.
REQ-010 SHALL have port reset_out, output, NUM_OUT bits: active-high per-channel reset; bit 0 releases first.
REQ-011 SHALL have port done, output, 1 bit: high when every channel is released (state RUN).

Function
REQ-012 SHALL pass pll_lock through a LOCK_SYNC-flop synchroniser; the last stage is lock_sync.
REQ-013 SHALL keep a filter counter: +1 per edge with lock_sync=1, saturating at LOCK_FILT; cleared on any edge with lock_sync=0; lock_ok = (counter==LOCK_FILT).
REQ-014 Filter counter SHALL run independently of req and of the state machine.
REQ-015 SHALL implement four states: WAIT_LOCK, HOLD, RELEASE, RUN.
REQ-016 Priority each edge SHALL be: rst_n low > (req=1 or lock_ok=0) > normal sequencing.
REQ-017 In any state, req=1 or lock_ok=0 SHALL force WAIT_LOCK at the next edge, with all reset_out bits set to 1 and done cleared on that same edge.
REQ-018 WAIT_LOCK SHALL move to HOLD when lock_ok=1 and req=0, clearing the hold counter.
REQ-019 HOLD SHALL last exactly HOLD_CYCLES cycles, then move to RELEASE and clear reset_out[0] on the transition edge.
REQ-020 In RELEASE, reset_out[i] SHALL clear exactly STAGE_GAP cycles after reset_out[i-1]; released bits stay 0 until REQ-017 applies.
REQ-021 On the edge that clears reset_out[NUM_OUT-1], the state SHALL become RUN and done SHALL go 1.
REQ-022 With NUM_OUT=1, reset_out[0] SHALL clear and done SHALL set on the same edge (HOLD to RUN directly).
REQ-023 Latency SHALL be fixed: reset_out[0] clears LOCK_SYNC+LOCK_FILT+1+HOLD_CYCLES edges after pll_lock rises with req=0 throughout, with the rise meeting setup before the first edge.
REQ-024 reset_out SHALL always be thermometer-coded: released bits form a contiguous group starting at bit 0.
REQ-025 All outputs SHALL be driven directly from registers, with no combinational path from an input to an output.

Reset
REQ-026 While rst_n=0, reset_out SHALL be all ones, done 0, state WAIT_LOCK, and the synchroniser, filter, hold and stage counters 0.
REQ-027 Assertion of rst_n SHALL act asynchronously, with no clock required; deassertion SHALL take effect at the first edge after it.
REQ-028 rst_n low mid-sequence (HOLD, RELEASE or RUN) SHALL abort the sequence immediately; the full sequence restarts after rst_n rises.

Configuration
REQ-029 Macro RSTSEQ_LOCK_LOSS_CNT_EN, when defined, SHALL add output lock_loss_cnt (8 bits). It increments, saturating at 255, on each edge where lock_ok=0 forces HOLD, RELEASE or RUN to WAIT_LOCK; it is not incremented by req; rst_n clears it to 0.
REQ-030 Without RSTSEQ_LOCK_LOSS_CNT_EN, the lock_loss_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults NUM_OUT=3, LOCK_SYNC=2, LOCK_FILT=3, HOLD_CYCLES=4, STAGE_GAP=2)
REQ-031 Release timing: rst_n rises, then pll_lock rises before edge 1 with req=0. Required: reset_out=3'b111 through edge 9, 3'b110 after edge 10, 3'b100 after edge 12, 3'b000 and done=1 after edge 14.
REQ-032 Lock glitch in RUN: pll_lock low for 1 cycle. Required: all reset_out=1 and done=0 LOCK_SYNC+1 edges after the sample. With the macro, lock_loss_cnt goes 0 to 1; the re-release follows REQ-031 timing.
REQ-033 req pulse in RELEASE: 1-cycle req after reset_out=3'b110. Required: 3'b111 at the next edge; release restarts at HOLD on the following edge (lock_ok still 1); lock_loss_cnt unchanged.
REQ-034 Async abort: rst_n pulled low mid-HOLD between edges. Required: reset_out=3'b111 and done=0 with no clock edge; filter restarts from 0 after rst_n rises.
REQ-035 Filter reject: pll_lock toggling 1,1,0,1,1,0 repeatedly. Required: lock_ok never asserts and reset_out stays 3'b111 indefinitely.
REQ-036 Saturation, macro defined: 300 lock-loss events from RUN. Required: lock_loss_cnt=255 and holds; NUM_OUT=1 build shows reset_out[0]=0 and done=1 on the same edge.
